// File: rtl/om_arb_pkg.sv
// Shared definitions for the output-memory write arbiter: source ids,
// channel count, the {addr, data} entry layout and the grant functions
// used by the arbiter stage.
package om_arb_pkg;

    // Number of detector channels feeding the output memory.
    localparam int NUM_CH = 3;

    // Source ids as seen on oSrc; also the bit index of each channel in
    // the packed per-channel vectors inside the arbiter.
    typedef enum logic [1:0] {
        SRC_23 = 2'd0,
        SRC_19 = 2'd1,
        SRC_17 = 2'd2
    } om_src_e;

    // Default output-memory geometry.
    localparam int OM_ADDR_W = 13;
    localparam int OM_DATA_W = 32;

    // One FIFO entry: address in the upper bits, data in the lower bits.
    // The arbiter packs its FIFO words in this same order for any width.
    typedef struct packed {
        logic [OM_ADDR_W-1:0] addr;
        logic [OM_DATA_W-1:0] data;
    } om_entry_t;

    // Fixed priority pick: 23 beats 19 beats 17. Returns a one-hot grant.
    function automatic logic [NUM_CH-1:0] fixedGrant(input logic [NUM_CH-1:0] req);
        logic [NUM_CH-1:0] gnt;
        gnt = '0;
        if (req[0]) begin
            gnt = 3'b001;
        end else if (req[1]) begin
            gnt = 3'b010;
        end else if (req[2]) begin
            gnt = 3'b100;
        end
        return gnt;
    endfunction

    // Round-robin pick: the search begins at the channel after 'last' and
    // wraps 23 -> 19 -> 17 -> 23. Returns a one-hot grant.
    function automatic logic [NUM_CH-1:0] rrGrant(input logic [NUM_CH-1:0] req,
                                                 input om_src_e last);
        logic [NUM_CH-1:0] gnt;
        gnt = '0;
        case (last)
            SRC_23: begin
                if (req[1]) begin
                    gnt = 3'b010;
                end else if (req[2]) begin
                    gnt = 3'b100;
                end else if (req[0]) begin
                    gnt = 3'b001;
                end
            end
            SRC_19: begin
                if (req[2]) begin
                    gnt = 3'b100;
                end else if (req[0]) begin
                    gnt = 3'b001;
                end else if (req[1]) begin
                    gnt = 3'b010;
                end
            end
            default: begin
                if (req[0]) begin
                    gnt = 3'b001;
                end else if (req[1]) begin
                    gnt = 3'b010;
                end else if (req[2]) begin
                    gnt = 3'b100;
                end
            end
        endcase
        return gnt;
    endfunction

endpackage

// File: rtl/om_arb_fifo.sv
// Per-channel synchronous FIFO for the output-memory write arbiter.
// A push is accepted only while the registered full flag is low, so a
// pop in the same cycle never makes room for that cycle's push.
// DEPTH must be a power of two so the pointers wrap naturally.
module om_arb_fifo #(
    parameter int WIDTH = 45,
    parameter int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] head_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, full_d;
    logic             pushOk;
    logic             popOk;

    assign pushOk = push_i && !full_q;
    assign popOk  = pop_i && (count_q != '0);

    // Next pointer/count/full values; pointers wrap modulo DEPTH by width.
    always_comb begin
        wrPtr_d = wrPtr_q + PTR_W'(pushOk);
        rdPtr_d = rdPtr_q + PTR_W'(popOk);
        count_d = count_q + CNT_W'(pushOk) - CNT_W'(popOk);
        full_d  = (count_d == CNT_W'(DEPTH));
    end

    // Pointer, occupancy and full-flag registers; reset empties the FIFO.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
            full_q  <= full_d;
        end
    end

    // Storage array; contents need no reset because count gates every read.
    always_ff @(posedge clk_i) begin
        if (pushOk) begin
            mem[wrPtr_q] <= data_i;
        end
    end

    assign head_o  = mem[rdPtr_q];
    assign count_o = count_q;
    assign full_o  = full_q;
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/om_write_arbiter.sv
// Output-memory write arbiter: three detector channels (23x23, 19x19,
// 17x17) each buffer writes in their own FIFO; an arbiter moves one head
// per cycle into a single registered output slot with a valid/ready
// handshake towards the output memory.
// Build option: define OM_ARB_FIXED_PRIO_EN for fixed priority
// 23 > 19 > 17 with no last-grant history; default is round-robin.
module om_write_arbiter
    import om_arb_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 13,
    parameter int DEPTH  = 4
) (
    input  logic              iClk,
    input  logic              iReset,
    input  logic              iWrreq_23,
    input  logic              iWrreq_19,
    input  logic              iWrreq_17,
    input  logic [ADDR_W-1:0] iAddr_23,
    input  logic [ADDR_W-1:0] iAddr_19,
    input  logic [ADDR_W-1:0] iAddr_17,
    input  logic [DATA_W-1:0] iData_23,
    input  logic [DATA_W-1:0] iData_19,
    input  logic [DATA_W-1:0] iData_17,
    output logic              oFull_23,
    output logic              oFull_19,
    output logic              oFull_17,
    input  logic              iReady_OM,
    output logic              oWrreq_OM,
    output logic [ADDR_W-1:0] oAddr_OM,
    output logic [DATA_W-1:0] oData_OM,
    output logic [1:0]        oSrc,
    output logic [2:0]        oOverflow,
    output logic              oIdle
);

    localparam int ENTRY_W = ADDR_W + DATA_W;
    localparam int CNT_W   = $clog2(DEPTH + 1);

    logic [NUM_CH-1:0]  wrreq;
    logic [NUM_CH-1:0]  pushReq;
    logic [NUM_CH-1:0]  fullQ;
    logic [NUM_CH-1:0]  emptyQ;
    logic [NUM_CH-1:0]  grant;
    logic [ENTRY_W-1:0] entryIn [NUM_CH];
    logic [ENTRY_W-1:0] head    [NUM_CH];
    logic [CNT_W-1:0]   count   [NUM_CH];

    logic [ENTRY_W-1:0] grantHead;
    om_src_e            grantSrc;
    logic               slotLoad;

    logic               slotValid_q, slotValid_d;
    logic [ADDR_W-1:0]  slotAddr_q,  slotAddr_d;
    logic [DATA_W-1:0]  slotData_q,  slotData_d;
    om_src_e            slotSrc_q,   slotSrc_d;
    logic [NUM_CH-1:0]  overflow_q,  overflow_d;

    // Channel vectors are indexed by source id: bit0 = 23, bit1 = 19, bit2 = 17.
    assign wrreq      = {iWrreq_17, iWrreq_19, iWrreq_23};
    assign entryIn[0] = {iAddr_23, iData_23};
    assign entryIn[1] = {iAddr_19, iData_19};
    assign entryIn[2] = {iAddr_17, iData_17};

    // A write landing on a full FIFO is dropped; the FIFO never sees it.
    assign pushReq = wrreq & ~fullQ;

    om_arb_fifo #(.WIDTH(ENTRY_W), .DEPTH(DEPTH)) u_fifo23 (
        .clk_i   (iClk),
        .rst_i   (iReset),
        .push_i  (pushReq[0]),
        .pop_i   (grant[0]),
        .data_i  (entryIn[0]),
        .head_o  (head[0]),
        .count_o (count[0]),
        .full_o  (fullQ[0]),
        .empty_o (emptyQ[0])
    );

    om_arb_fifo #(.WIDTH(ENTRY_W), .DEPTH(DEPTH)) u_fifo19 (
        .clk_i   (iClk),
        .rst_i   (iReset),
        .push_i  (pushReq[1]),
        .pop_i   (grant[1]),
        .data_i  (entryIn[1]),
        .head_o  (head[1]),
        .count_o (count[1]),
        .full_o  (fullQ[1]),
        .empty_o (emptyQ[1])
    );

    om_arb_fifo #(.WIDTH(ENTRY_W), .DEPTH(DEPTH)) u_fifo17 (
        .clk_i   (iClk),
        .rst_i   (iReset),
        .push_i  (pushReq[2]),
        .pop_i   (grant[2]),
        .data_i  (entryIn[2]),
        .head_o  (head[2]),
        .count_o (count[2]),
        .full_o  (fullQ[2]),
        .empty_o (emptyQ[2])
    );

    // The slot can take a new word when it is empty or being drained now,
    // which is what lets back-to-back loads run at one word per cycle.
    assign slotLoad = !slotValid_q || iReady_OM;

`ifdef OM_ARB_FIXED_PRIO_EN
    // Fixed-priority grant among non-empty channels when the slot can load.
    always_comb begin
        grant = '0;
        if (slotLoad) begin
            grant = fixedGrant(~emptyQ);
        end
    end
`else
    om_src_e lastGrant_q;

    // Round-robin grant among non-empty channels when the slot can load.
    always_comb begin
        grant = '0;
        if (slotLoad) begin
            grant = rrGrant(~emptyQ, lastGrant_q);
        end
    end

    // Last-grant pointer moves only on a grant; reset points at 17 so 23 goes first.
    always_ff @(posedge iClk) begin
        if (iReset) begin
            lastGrant_q <= SRC_17;
        end else if (|grant) begin
            lastGrant_q <= grantSrc;
        end
    end
`endif

    // Select the granted channel's head word and its source id.
    always_comb begin
        grantSrc  = SRC_23;
        grantHead = head[0];
        if (grant[1]) begin
            grantSrc  = SRC_19;
            grantHead = head[1];
        end else if (grant[2]) begin
            grantSrc  = SRC_17;
            grantHead = head[2];
        end
    end

    // Output slot next state: reload or empty on a load cycle, else hold.
    always_comb begin
        slotValid_d = slotValid_q;
        slotAddr_d  = slotAddr_q;
        slotData_d  = slotData_q;
        slotSrc_d   = slotSrc_q;
        if (slotLoad) begin
            slotValid_d = |grant;
            if (|grant) begin
                {slotAddr_d, slotData_d} = grantHead;
                slotSrc_d                = grantSrc;
            end
        end
    end

    // Output slot registers; reset discards any pending word.
    always_ff @(posedge iClk) begin
        if (iReset) begin
            slotValid_q <= 1'b0;
            slotAddr_q  <= '0;
            slotData_q  <= '0;
            slotSrc_q   <= SRC_23;
        end else begin
            slotValid_q <= slotValid_d;
            slotAddr_q  <= slotAddr_d;
            slotData_q  <= slotData_d;
            slotSrc_q   <= slotSrc_d;
        end
    end

    // Sticky drop flags: set by a write into a full FIFO.
    always_comb begin
        overflow_d = overflow_q | (wrreq & fullQ);
    end

    // Drop flags clear only on reset.
    always_ff @(posedge iClk) begin
        if (iReset) begin
            overflow_q <= '0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    assign oWrreq_OM = slotValid_q;
    assign oAddr_OM  = slotAddr_q;
    assign oData_OM  = slotData_q;
    assign oSrc      = slotSrc_q;
    assign oOverflow = overflow_q;
    assign oFull_23  = fullQ[0];
    assign oFull_19  = fullQ[1];
    assign oFull_17  = fullQ[2];
    assign oIdle     = (count[0] == '0) && (count[1] == '0) &&
                       (count[2] == '0) && !slotValid_q;

endmodule

// File: tb/tb_om_write_arbiter.sv
// Testbench for om_write_arbiter. Stimulus tasks push the expected words
// into per-channel queues and the expected source order into srcQ; a
// negedge monitor pops and compares on every output transfer.
// Expected source order follows the OM_ARB_FIXED_PRIO_EN build option.
`timescale 1ns/1ps
module tb_om_write_arbiter;

    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 13;
    localparam int DEPTH   = 4;
    localparam int ENTRY_W = ADDR_W + DATA_W;

    logic              iClk = 1'b0;
    logic              iReset = 1'b1;
    logic              iWrreq_23 = 1'b0, iWrreq_19 = 1'b0, iWrreq_17 = 1'b0;
    logic [ADDR_W-1:0] iAddr_23 = '0, iAddr_19 = '0, iAddr_17 = '0;
    logic [DATA_W-1:0] iData_23 = '0, iData_19 = '0, iData_17 = '0;
    logic              oFull_23, oFull_19, oFull_17;
    logic              iReady_OM = 1'b0;
    logic              oWrreq_OM;
    logic [ADDR_W-1:0] oAddr_OM;
    logic [DATA_W-1:0] oData_OM;
    logic [1:0]        oSrc;
    logic [2:0]        oOverflow;
    logic              oIdle;

    int total = 0;
    int bad   = 0;

    logic [1:0]         srcQ [$];
    logic [ENTRY_W-1:0] q23  [$];
    logic [ENTRY_W-1:0] q19  [$];
    logic [ENTRY_W-1:0] q17  [$];

    om_write_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .iClk      (iClk),
        .iReset    (iReset),
        .iWrreq_23 (iWrreq_23),
        .iWrreq_19 (iWrreq_19),
        .iWrreq_17 (iWrreq_17),
        .iAddr_23  (iAddr_23),
        .iAddr_19  (iAddr_19),
        .iAddr_17  (iAddr_17),
        .iData_23  (iData_23),
        .iData_19  (iData_19),
        .iData_17  (iData_17),
        .oFull_23  (oFull_23),
        .oFull_19  (oFull_19),
        .oFull_17  (oFull_17),
        .iReady_OM (iReady_OM),
        .oWrreq_OM (oWrreq_OM),
        .oAddr_OM  (oAddr_OM),
        .oData_OM  (oData_OM),
        .oSrc      (oSrc),
        .oOverflow (oOverflow),
        .oIdle     (oIdle)
    );

    always #5 iClk = ~iClk;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic logic [ADDR_W-1:0] mkAddr(input int c, input int n);
        return ADDR_W'(32'h100 * (c + 1) + n);
    endfunction

    function automatic logic [DATA_W-1:0] mkData(input int c, input int n);
        return 32'hC0DE_0000 | DATA_W'(c << 8) | DATA_W'(n);
    endfunction

    // Present a write on channel c for the next edge; queue it if it should be kept.
    task automatic driveWrite(input int c, input logic [ADDR_W-1:0] a,
                              input logic [DATA_W-1:0] d, input bit keep);
        case (c)
            0: begin
                iWrreq_23 = 1'b1; iAddr_23 = a; iData_23 = d;
                if (keep) q23.push_back({a, d});
            end
            1: begin
                iWrreq_19 = 1'b1; iAddr_19 = a; iData_19 = d;
                if (keep) q19.push_back({a, d});
            end
            default: begin
                iWrreq_17 = 1'b1; iAddr_17 = a; iData_17 = d;
                if (keep) q17.push_back({a, d});
            end
        endcase
    endtask

    // Run one clock edge with the given ready, then withdraw all write requests.
    task automatic applyStimulus(input logic ready);
        iReady_OM = ready;
        @(posedge iClk);
        #1;
        iWrreq_23 = 1'b0;
        iWrreq_19 = 1'b0;
        iWrreq_17 = 1'b0;
    endtask

    task automatic doReset();
        iReset = 1'b1;
        applyStimulus(1'b0);
        applyStimulus(1'b0);
        iReset = 1'b0;
        srcQ.delete();
        q23.delete();
        q19.delete();
        q17.delete();
    endtask

    // Ready held high until every queued word has come out (bounded).
    task automatic drainAll(input string name);
        int n;
        n = 0;
        while ((srcQ.size() != 0 || oWrreq_OM) && n < 60) begin
            applyStimulus(1'b1);
            n++;
        end
        checkOutput({name, " drained"}, 64'(srcQ.size()), 64'd0);
        checkOutput({name, " leftover words"}, 64'(q23.size() + q19.size() + q17.size()), 64'd0);
    endtask

    // Scoreboard monitor: every accepted output word is checked against the queues.
    always @(negedge iClk) begin
        if (!iReset && oWrreq_OM && iReady_OM) begin
            logic [1:0]         expSrc;
            logic [ENTRY_W-1:0] expWord;
            bit                 have;
            if (srcQ.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected word: got src=%0d addr=0x%0h data=0x%0h expected none",
                         oSrc, oAddr_OM, oData_OM);
            end else begin
                expSrc = srcQ.pop_front();
                have   = 1'b0;
                expWord = '0;
                case (expSrc)
                    2'd0: if (q23.size() != 0) begin expWord = q23.pop_front(); have = 1'b1; end
                    2'd1: if (q19.size() != 0) begin expWord = q19.pop_front(); have = 1'b1; end
                    default: if (q17.size() != 0) begin expWord = q17.pop_front(); have = 1'b1; end
                endcase
                checkOutput("output src", 64'(oSrc), 64'(expSrc));
                if (have) begin
                    checkOutput("output addr/data", 64'({oAddr_OM, oData_OM}), 64'(expWord));
                end else begin
                    total++;
                    bad++;
                    $display("[TB] FAIL channel queue: got word for src %0d expected a queued word", expSrc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [ENTRY_W+1:0] held;
        int                 run;
        int                 maxRun;

        // Reset values
        applyStimulus(1'b0);
        applyStimulus(1'b0);
        checkOutput("reset wrreq", 64'(oWrreq_OM), 64'd0);
        checkOutput("reset addr/data/src", 64'({oSrc, oAddr_OM, oData_OM}), 64'd0);
        checkOutput("reset full", 64'({oFull_17, oFull_19, oFull_23}), 64'd0);
        checkOutput("reset overflow", 64'(oOverflow), 64'd0);
        checkOutput("reset idle", 64'(oIdle), 64'd1);
        iReset = 1'b0;

        // Single-channel latency
        driveWrite(0, 13'h010, 32'hA5A5_A5A5, 1'b1);
        srcQ.push_back(2'd0);
        applyStimulus(1'b1);
        checkOutput("latency edge1 wrreq", 64'(oWrreq_OM), 64'd0);
        checkOutput("latency edge1 idle", 64'(oIdle), 64'd0);
        applyStimulus(1'b1);
        checkOutput("latency edge2 wrreq", 64'(oWrreq_OM), 64'd1);
        checkOutput("latency edge2 word", 64'({oSrc, oAddr_OM, oData_OM}),
                    64'({2'd0, 13'h010, 32'hA5A5_A5A5}));
        applyStimulus(1'b1);
        checkOutput("latency after xfer wrreq", 64'(oWrreq_OM), 64'd0);
        checkOutput("latency after xfer idle", 64'(oIdle), 64'd1);

        // Arbitration order with all three channels loaded continuously
        doReset();
`ifdef OM_ARB_FIXED_PRIO_EN
        for (int c = 0; c < 3; c++)
            for (int k = 0; k < 4; k++) srcQ.push_back(2'(c));
`else
        for (int k = 0; k < 4; k++)
            for (int c = 0; c < 3; c++) srcQ.push_back(2'(c));
`endif
        run = 0;
        maxRun = 0;
        for (int t = 0; t < 18; t++) begin
            if (t < 4) begin
                for (int c = 0; c < 3; c++) driveWrite(c, mkAddr(c, t), mkData(c, t), 1'b1);
            end
            applyStimulus(1'b1);
            if (oWrreq_OM) run++;
            else run = 0;
            if (run > maxRun) maxRun = run;
        end
        checkOutput("arb one word per cycle", 64'(maxRun), 64'd12);
        checkOutput("arb no overflow", 64'(oOverflow), 64'd0);
        drainAll("arb");

        // Back-pressure on channel 19
        doReset();
        held = '0;
        for (int k = 0; k < 6; k++) begin
            driveWrite(1, mkAddr(1, k), mkData(1, k), k < 5);
            if (k < 5) srcQ.push_back(2'd1);
            applyStimulus(1'b0);
            if (k == 1) begin
                checkOutput("stall slot loaded", 64'(oWrreq_OM), 64'd1);
                held = {oSrc, oAddr_OM, oData_OM};
            end
            if (k == 3) checkOutput("stall full at count 3", 64'(oFull_19), 64'd0);
            if (k == 4) checkOutput("stall full at count 4", 64'(oFull_19), 64'd1);
        end
        checkOutput("stall full after drop", 64'(oFull_19), 64'd1);
        checkOutput("stall overflow", 64'(oOverflow), 64'b010);
        checkOutput("stall wrreq held", 64'(oWrreq_OM), 64'd1);
        checkOutput("stall output stable", 64'({oSrc, oAddr_OM, oData_OM}), 64'(held));
        checkOutput("stall not idle", 64'(oIdle), 64'd0);

        // Full FIFO: push and pop in the same cycle, push must be rejected
        driveWrite(1, 13'h1FF, 32'hDEAD_BEEF, 1'b0);
        applyStimulus(1'b1);
        checkOutput("full boundary full flag", 64'(oFull_19), 64'd0);
        checkOutput("full boundary overflow", 64'(oOverflow), 64'b010);
        drainAll("backpressure");
        checkOutput("backpressure idle", 64'(oIdle), 64'd1);

        // Reset while the slot is stalled; overflow from above is still set
        driveWrite(0, mkAddr(0, 7), mkData(0, 7), 1'b0);
        applyStimulus(1'b0);
        driveWrite(0, mkAddr(0, 8), mkData(0, 8), 1'b0);
        applyStimulus(1'b0);
        checkOutput("pre-reset stall wrreq", 64'(oWrreq_OM), 64'd1);
        iReset = 1'b1;
        applyStimulus(1'b0);
        iReset = 1'b0;
        checkOutput("mid reset wrreq", 64'(oWrreq_OM), 64'd0);
        checkOutput("mid reset addr/data/src", 64'({oSrc, oAddr_OM, oData_OM}), 64'd0);
        checkOutput("mid reset full", 64'({oFull_17, oFull_19, oFull_23}), 64'd0);
        checkOutput("mid reset overflow", 64'(oOverflow), 64'd0);
        checkOutput("mid reset idle", 64'(oIdle), 64'd1);
        driveWrite(2, mkAddr(2, 9), mkData(2, 9), 1'b1);
        driveWrite(0, mkAddr(0, 9), mkData(0, 9), 1'b1);
        srcQ.push_back(2'd0);
        srcQ.push_back(2'd2);
        applyStimulus(1'b1);
        drainAll("post reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
